elelock_ctrl: RTL and testbench

//  PIN-entry sequencer for the electronic lock. Samples the raw one-hot tenkey
//  bus, debounces each press to a single digit event, and collects a DIGITS-long
//  BCD code. It compares the code with the stored code and drives lock/alarm.

---
 rtl/elelock_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_elelock_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/elelock_ctrl.sv
// elelock_ctrl: keypad PIN sequencer with debounce, compare and timed lockout.
// Define CODE_CHANGE_EN to add set_code_i and the in-field code change mode.
module elelock_ctrl #(
  parameter int                  DIGITS      = 4,
  parameter logic [DIGITS*4-1:0] CODE        = 16'h1234,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCKOUT_CYC = 1000,
  parameter int                  TIMEOUT_CYC = 500,
  localparam int                 CW          = $clog2(DIGITS+1)
) (
  input  logic          clk_i,
  input  logic          reset_i,
  input  logic [9:0]    tenkey_i,
  input  logic          close_i,
`ifdef CODE_CHANGE_EN
  input  logic          set_code_i,
`endif
  output logic          lock_o,
  output logic          alarm_o,
  output logic [CW-1:0] entry_cnt_o
);

  localparam int BW   = DIGITS*4;
  localparam int TMAX = (LOCKOUT_CYC > TIMEOUT_CYC) ? LOCKOUT_CYC
                                                    : TIMEOUT_CYC;
  localparam int TW   = $clog2(TMAX+1);
  localparam int FW   = $clog2(MAX_FAIL+1);

  typedef enum logic [2:0] {
    S_LOCKED,
    S_ENTRY,
    S_CHECK,
    S_OPEN,
`ifdef CODE_CHANGE_EN
    S_SETCODE,
`endif
    S_LOCKOUT
  } state_t;

  state_t          state_q;
  logic [9:0]      tk_q;
  logic [9:0]      tk_p;
  logic [BW-1:0]   buf_q;
  logic [BW-1:0]   buf_d;
  logic [BW-1:0]   code_w;
  logic [CW-1:0]   cnt_q;
  logic [FW-1:0]   fail_q;
  logic [FW-1:0]   fail_d;
  logic [TW-1:0]   timer_q;
  logic [TW-1:0]   timer_d;
  logic            lock_q;
  logic            alarm_q;
  logic            onehot;
  logic            kp;
  logic            timeout;
  logic [3:0]      digit;

`ifdef CODE_CHANGE_EN
  logic [BW-1:0]   code_q;
  logic [BW-1:0]   shadow_q;
  logic [BW-1:0]   shadow_d;
  assign code_w   = code_q;
  assign shadow_d = {shadow_q[BW-5:0], digit};
`else
  assign code_w = CODE;
`endif

  // A press is the first cycle a clean single key follows an idle bus.
  always_comb begin
    onehot = (tk_q != '0) && ((tk_q & (tk_q - 10'd1)) == '0);
    kp     = onehot && (tk_p == '0);
    digit  = '0;
    for (int i = 0; i < 10; i++) begin
      if (tk_q[i]) digit = 4'(i);
    end
  end

  assign buf_d   = {buf_q[BW-5:0], digit};
  assign fail_d  = (fail_q == FW'(MAX_FAIL)) ? fail_q : fail_q + 1'b1;
  assign timer_d = (timer_q == TW'(TMAX)) ? timer_q : timer_q + 1'b1;
  assign timeout = (timer_q == TW'(TIMEOUT_CYC-1));

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q  <= S_LOCKED;
      tk_q     <= '0;
      tk_p     <= '0;
      buf_q    <= '0;
      cnt_q    <= '0;
      fail_q   <= '0;
      timer_q  <= '0;
      lock_q   <= 1'b1;
      alarm_q  <= 1'b0;
`ifdef CODE_CHANGE_EN
      code_q   <= CODE;
      shadow_q <= '0;
`endif
    end else begin
      tk_q    <= tenkey_i;
      tk_p    <= tk_q;
      timer_q <= timer_d;
      unique case (state_q)
        S_LOCKED: begin
          if (kp) begin
            buf_q   <= buf_d;
            cnt_q   <= CW'(1);
            timer_q <= '0;
            state_q <= S_ENTRY;
          end
        end
        S_ENTRY: begin
          if (cnt_q == CW'(DIGITS)) begin
            timer_q <= '0;
            state_q <= S_CHECK;
          end else if (kp) begin
            buf_q   <= buf_d;
            cnt_q   <= cnt_q + 1'b1;
            timer_q <= '0;
          end else if (timeout) begin
            buf_q   <= '0;
            cnt_q   <= '0;
            timer_q <= '0;
            state_q <= S_LOCKED;
          end
        end
        S_CHECK: begin
          buf_q   <= '0;
          cnt_q   <= '0;
          timer_q <= '0;
          if (buf_q == code_w) begin
            lock_q  <= 1'b0;
            fail_q  <= '0;
            state_q <= S_OPEN;
          end else begin
            fail_q <= fail_d;
            if (fail_d == FW'(MAX_FAIL)) begin
              alarm_q <= 1'b1;
              state_q <= S_LOCKOUT;
            end else begin
              state_q <= S_LOCKED;
            end
          end
        end
        S_OPEN: begin
          if (close_i) begin
            lock_q  <= 1'b1;
            timer_q <= '0;
            state_q <= S_LOCKED;
          end
`ifdef CODE_CHANGE_EN
          else if (set_code_i) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            state_q  <= S_SETCODE;
          end
`endif
        end
`ifdef CODE_CHANGE_EN
        S_SETCODE: begin
          if (kp) begin
            timer_q <= '0;
            if (cnt_q == CW'(DIGITS-1)) begin
              code_q   <= shadow_d;
              shadow_q <= '0;
              cnt_q    <= '0;
              state_q  <= S_OPEN;
            end else begin
              shadow_q <= shadow_d;
              cnt_q    <= cnt_q + 1'b1;
            end
          end else if (timeout) begin
            shadow_q <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            state_q  <= S_OPEN;
          end
        end
`endif
        S_LOCKOUT: begin
          if (timer_q == TW'(LOCKOUT_CYC-1)) begin
            alarm_q <= 1'b0;
            fail_q  <= '0;
            timer_q <= '0;
            state_q <= S_LOCKED;
          end
        end
        default: state_q <= S_LOCKED;
      endcase
    end
  end

  assign lock_o      = lock_q;
  assign alarm_o     = alarm_q;
  assign entry_cnt_o = cnt_q;

endmodule

// File: tb/tb_elelock_ctrl.sv
// tb_elelock_ctrl: scenario tasks with a cycle-stamped expectation queue.
// Define CODE_CHANGE_EN to also exercise the code change mode.
module tb_elelock_ctrl;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] tenkey;
  logic       close;
  logic       set_code;
  logic       lock;
  logic       alarm;
  logic [2:0] cnt;

  typedef struct {
    int         cyc;
    logic       lock;
    logic       alarm;
    logic [2:0] cnt;
    string      tag;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad   = 0;
  int   cyc   = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  elelock_ctrl dut (
    .clk_i       (clk),
    .reset_i     (reset),
    .tenkey_i    (tenkey),
    .close_i     (close),
`ifdef CODE_CHANGE_EN
    .set_code_i  (set_code),
`endif
    .lock_o      (lock),
    .alarm_o     (alarm),
    .entry_cnt_o (cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // s returns the edge number that first samples the key into tk_q
  task automatic press(input int d, output int s);
    tenkey    = '0;
    tenkey[d] = 1'b1;
    s         = cyc + 1;
    repeat (3) tick();
    tenkey = '0;
    repeat (3) tick();
  endtask

  task automatic enter4(input int a, input int b, input int c, input int d);
    int s;
    press(a, s);
    press(b, s);
    press(c, s);
    press(d, s);
    repeat (2) tick();
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    tenkey = '0;
    close  = 1'b0;
    set_code = 1'b0;
    tick();
    total += 3;
    if (lock !== 1'b1) begin
      bad++; $display("FAIL reset_lock: got %b want 1", lock);
    end
    if (alarm !== 1'b0) begin
      bad++; $display("FAIL reset_alarm: got %b want 0", alarm);
    end
    if (cnt !== 3'd0) begin
      bad++; $display("FAIL reset_cnt: got %0d want 0", cnt);
    end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_unlock();
    int   s;
    exp_t e;
    press(1, s);
    press(2, s);
    press(3, s);
    tenkey    = '0;
    tenkey[4] = 1'b1;
    s         = cyc + 1;
    // tk_q at s, shift at s+1, CHECK entered s+2, OPEN at s+3
    sbq.push_back('{s,     1'b1, 1'b0, 3'd3, "unlock_sample"});
    sbq.push_back('{s + 1, 1'b1, 1'b0, 3'd4, "unlock_shift"});
    sbq.push_back('{s + 2, 1'b1, 1'b0, 3'd4, "unlock_check"});
    sbq.push_back('{s + 3, 1'b0, 1'b0, 3'd0, "unlock_open"});
    sbq.push_back('{s + 7, 1'b0, 1'b0, 3'd0, "unlock_stay"});
    for (int k = 0; k < 8; k++) begin
      tick();
      if (k == 2) tenkey = '0;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (e.cyc != cyc || lock !== e.lock || alarm !== e.alarm
            || cnt !== e.cnt) begin
          bad++;
          $display("FAIL %s @%0d: got l=%b a=%b n=%0d want l=%b a=%b n=%0d @%0d",
                   e.tag, cyc, lock, alarm, cnt, e.lock, e.alarm, e.cnt, e.cyc);
        end
      end
    end
    close = 1'b1;
    sbq.push_back('{cyc + 1, 1'b1, 1'b0, 3'd0, "close_relock"});
    tick();
    close = 1'b0;
    while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
      e = sbq.pop_front();
      total++;
      if (e.cyc != cyc || lock !== e.lock || alarm !== e.alarm
          || cnt !== e.cnt) begin
        bad++;
        $display("FAIL %s @%0d: got l=%b a=%b n=%0d want l=%b a=%b n=%0d",
                 e.tag, cyc, lock, alarm, cnt, e.lock, e.alarm, e.cnt);
      end
    end
    tick();
  endtask

  task automatic test_lockout();
    int   s;
    int   n;
    int   nz;
    exp_t e;
    for (int t = 0; t < 2; t++) begin
      enter4(1, 2, 3, 5);
      total++;
      if (lock !== 1'b1 || alarm !== 1'b0) begin
        bad++;
        $display("FAIL wrong_code_%0d: got l=%b a=%b want l=1 a=0",
                 t, lock, alarm);
      end
    end
    press(1, s);
    press(2, s);
    press(3, s);
    tenkey    = '0;
    tenkey[5] = 1'b1;
    s         = cyc + 1;
    sbq.push_back('{s + 2, 1'b1, 1'b0, 3'd4, "lockout_check"});
    sbq.push_back('{s + 3, 1'b1, 1'b1, 3'd0, "lockout_enter"});
    for (int k = 0; k < 4; k++) begin
      tick();
      if (k == 2) tenkey = '0;
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (e.cyc != cyc || lock !== e.lock || alarm !== e.alarm
            || cnt !== e.cnt) begin
          bad++;
          $display("FAIL %s @%0d: got l=%b a=%b n=%0d want l=%b a=%b n=%0d",
                   e.tag, cyc, lock, alarm, cnt, e.lock, e.alarm, e.cnt);
        end
      end
    end
    n  = 0;
    nz = 0;
    while (alarm === 1'b1 && n < 1100) begin
      n++;
      if (cnt !== 3'd0) nz++;
      tenkey = '0;
      if (n < 990 && (n % 6) < 3) tenkey[(n / 6) % 10] = 1'b1;
      tick();
    end
    tenkey = '0;
    total += 3;
    if (n != 1000) begin
      bad++; $display("FAIL alarm_len: got %0d cycles want 1000", n);
    end
    if (nz != 0) begin
      bad++; $display("FAIL lockout_keys: got %0d nonzero cnt want 0", nz);
    end
    if (lock !== 1'b1 || alarm !== 1'b0) begin
      bad++;
      $display("FAIL lockout_exit: got l=%b a=%b want l=1 a=0", lock, alarm);
    end
    repeat (4) tick();
    enter4(1, 2, 3, 5);
    total++;
    if (lock !== 1'b1 || alarm !== 1'b0) begin
      bad++;
      $display("FAIL fail_cnt_cleared: got l=%b a=%b want l=1 a=0",
               lock, alarm);
    end
    enter4(1, 2, 3, 4);
    total++;
    if (lock !== 1'b0) begin
      bad++; $display("FAIL post_lockout_open: got %b want 0", lock);
    end
    close = 1'b1;
    tick();
    close = 1'b0;
    tick();
  endtask

  task automatic test_timeout();
    int   s;
    exp_t e;
    press(1, s);
    press(2, s);
    // last press shifts at s+1; 500 idle cycles later the entry is dropped
    sbq.push_back('{s + 500, 1'b1, 1'b0, 3'd2, "timeout_before"});
    sbq.push_back('{s + 501, 1'b1, 1'b0, 3'd0, "timeout_clear"});
    while (cyc < s + 501) begin
      tick();
      while (sbq.size() != 0 && sbq[0].cyc <= cyc) begin
        e = sbq.pop_front();
        total++;
        if (e.cyc != cyc || lock !== e.lock || alarm !== e.alarm
            || cnt !== e.cnt) begin
          bad++;
          $display("FAIL %s @%0d: got l=%b a=%b n=%0d want l=%b a=%b n=%0d",
                   e.tag, cyc, lock, alarm, cnt, e.lock, e.alarm, e.cnt);
        end
      end
    end
    enter4(1, 2, 3, 4);
    total++;
    if (lock !== 1'b0) begin
      bad++; $display("FAIL timeout_then_open: got %b want 0", lock);
    end
    close = 1'b1;
    tick();
    close = 1'b0;
    tick();
  endtask

  task automatic test_hold_chord();
    int s;
    close = 1'b1;
    repeat (3) tick();
    close = 1'b0;
    total++;
    if (lock !== 1'b1) begin
      bad++; $display("FAIL close_in_locked: got %b want 1", lock);
    end
    tenkey    = '0;
    tenkey[7] = 1'b1;
    repeat (20) tick();
    total++;
    if (cnt !== 3'd1) begin
      bad++; $display("FAIL hold_key: got %0d want 1", cnt);
    end
    tenkey = '0;
    repeat (3) tick();
    tenkey = 10'b0000000110;
    repeat (5) tick();
    tenkey = '0;
    repeat (3) tick();
    total++;
    if (cnt !== 3'd1) begin
      bad++; $display("FAIL chord: got %0d want 1", cnt);
    end
    press(8, s);
    press(9, s);
    total++;
    if (cnt !== 3'd3) begin
      bad++; $display("FAIL after_chord: got %0d want 3", cnt);
    end
  endtask

  task automatic test_reset_mid();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    total++;
    if (cnt !== 3'd0 || lock !== 1'b1 || alarm !== 1'b0) begin
      bad++;
      $display("FAIL reset_mid: got n=%0d l=%b a=%b want n=0 l=1 a=0",
               cnt, lock, alarm);
    end
    tick();
  endtask

`ifdef CODE_CHANGE_EN
  task automatic test_code_change();
    int s;
    enter4(1, 2, 3, 4);
    set_code = 1'b1;
    tick();
    set_code = 1'b0;
    press(9, s);
    press(8, s);
    close = 1'b1;
    tick();
    close = 1'b0;
    total++;
    if (lock !== 1'b0) begin
      bad++; $display("FAIL close_in_setcode: got %b want 0", lock);
    end
    press(7, s);
    press(6, s);
    total++;
    if (lock !== 1'b0 || cnt !== 3'd0) begin
      bad++;
      $display("FAIL setcode_done: got l=%b n=%0d want l=0 n=0", lock, cnt);
    end
    close = 1'b1;
    tick();
    close = 1'b0;
    total++;
    if (lock !== 1'b1) begin
      bad++; $display("FAIL setcode_close: got %b want 1", lock);
    end
    enter4(1, 2, 3, 4);
    total++;
    if (lock !== 1'b1) begin
      bad++; $display("FAIL old_code: got %b want 1", lock);
    end
    enter4(9, 8, 7, 6);
    total++;
    if (lock !== 1'b0) begin
      bad++; $display("FAIL new_code: got %b want 0", lock);
    end
    close = 1'b1;
    tick();
    close = 1'b0;
  endtask
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    reset    = 1'b1;
    tenkey   = '0;
    close    = 1'b0;
    set_code = 1'b0;
    test_reset();
    test_unlock();
    test_lockout();
    test_timeout();
    test_hold_chord();
    test_reset_mid();
`ifdef CODE_CHANGE_EN
    test_code_change();
`endif
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
